// File: rtl/reg_bank_pkg.sv
// Shared types for the register-bank controller: command opcodes and FSM states.
// StVfy exists only when REG_BANK_CTRL_READBACK_EN is defined.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    OpWrite = 2'b00,
    OpRead  = 2'b01,
    OpClear = 2'b10,
    OpFill  = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StCap,
    StRsp,
    StSweep
`ifdef REG_BANK_CTRL_READBACK_EN
    ,
    StVfy
`endif
  } state_e;

endpackage

// File: rtl/reg_bank_sweep_cnt.sv
// Address sweep counter for FILL/CLEAR: loads start/end, steps modulo 2^N,
// and flags the terminal address so equal start/end gives a single write.
module reg_bank_sweep_cnt #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         advance,
  input  logic [N-1:0] start,
  input  logic [N-1:0] stop,
  output logic [N-1:0] next,
  output logic         last
);

  logic [N-1:0] cnt_q;
  logic [N-1:0] end_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      end_q <= '0;
    end else if (load) begin
      cnt_q <= start;
      end_q <= stop;
    end else if (advance) begin
      cnt_q <= next;
    end
  end

  // Natural N-bit overflow provides the wrap from 2^N-1 to 0.
  assign next = cnt_q + N'(1);
  assign last = (cnt_q == end_q);

endmodule

// File: rtl/reg_bank_ctrl.sv
// Register-bank command controller: WRITE, READ with response handshake, FILL and CLEAR sweeps.
// Define REG_BANK_CTRL_READBACK_EN to add a read-back verify cycle after each WRITE.
module reg_bank_ctrl
  import reg_bank_pkg::*;
#(
  parameter int unsigned W = 7,
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [N-1:0] cmd_addr_a,
  input  logic [N-1:0] cmd_addr_b,
  input  logic [W-1:0] cmd_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_a,
  output logic [W-1:0] rsp_b,
  output logic         busy,
  output logic         err,
  output logic         we,
  output logic [N-1:0] addr_rd,
  output logic [W-1:0] data_in,
  output logic [N-1:0] addr_rs1,
  output logic [N-1:0] addr_rs2,
  input  logic [W-1:0] rs1,
  input  logic [W-1:0] rs2
);

  state_e       state_q;
  logic         is_sweep_op;
  logic         sweep_load;
  logic [N-1:0] sweep_start;
  logic [N-1:0] sweep_stop;
  logic [N-1:0] sweep_next;
  logic         sweep_last;

  always_comb begin
    is_sweep_op = (cmd_op == OpClear) || (cmd_op == OpFill);
    sweep_load  = cmd_valid && (state_q == StIdle) && is_sweep_op;
    // CLEAR is a FILL over the whole bank with zero data.
    sweep_start = (cmd_op == OpClear) ? '0 : cmd_addr_a;
    sweep_stop  = (cmd_op == OpClear) ? '1 : cmd_addr_b;
  end

  reg_bank_sweep_cnt #(
    .N (N)
  ) u_sweep_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (sweep_load),
    .advance (state_q == StSweep),
    .start   (sweep_start),
    .stop    (sweep_stop),
    .next    (sweep_next),
    .last    (sweep_last)
  );

`ifdef REG_BANK_CTRL_READBACK_EN
  logic err_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      we        <= 1'b0;
      addr_rd   <= '0;
      data_in   <= '0;
      addr_rs1  <= '0;
      addr_rs2  <= '0;
      rsp_valid <= 1'b0;
      rsp_a     <= '0;
      rsp_b     <= '0;
`ifdef REG_BANK_CTRL_READBACK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      we <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            unique case (cmd_op_e'(cmd_op))
              OpWrite: begin
                state_q <= StWr;
                we      <= 1'b1;
                addr_rd <= cmd_addr_a;
                data_in <= cmd_data;
              end
              OpRead: begin
                state_q  <= StRd;
                addr_rs1 <= cmd_addr_a;
                addr_rs2 <= cmd_addr_b;
              end
              OpClear, OpFill: begin
                state_q <= StSweep;
                we      <= 1'b1;
                addr_rd <= sweep_start;
                data_in <= (cmd_op == OpClear) ? '0 : cmd_data;
              end
              default: state_q <= StIdle;
            endcase
          end
        end
        StWr: begin
`ifdef REG_BANK_CTRL_READBACK_EN
          state_q  <= StVfy;
          addr_rs1 <= addr_rd;
`else
          state_q  <= StIdle;
`endif
        end
        StRd: begin
          rsp_a   <= rs1;
          rsp_b   <= rs2;
          state_q <= StCap;
        end
        StCap: begin
          rsp_valid <= 1'b1;
          state_q   <= StRsp;
        end
        StRsp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        StSweep: begin
          if (sweep_last) begin
            state_q <= StIdle;
          end else begin
            we      <= 1'b1;
            addr_rd <= sweep_next;
          end
        end
`ifdef REG_BANK_CTRL_READBACK_EN
        StVfy: begin
          // rs1 reflects the bank at the just-written address this cycle.
          if (rs1 != data_in) err_q <= 1'b1;
          state_q <= StIdle;
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);

`ifdef REG_BANK_CTRL_READBACK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Scoreboard bench for reg_bank_ctrl with a behavioural 16-entry register bank.
module tb_reg_bank_ctrl;
  import reg_bank_pkg::*;

  localparam int unsigned W = 7;
  localparam int unsigned N = 4;
`ifdef REG_BANK_CTRL_READBACK_EN
  localparam int WrCycles  = 2;
  localparam int ErrExpect = 1;
`else
  localparam int WrCycles  = 1;
  localparam int ErrExpect = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [N-1:0] cmd_addr_a;
  logic [N-1:0] cmd_addr_b;
  logic [W-1:0] cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_a;
  logic [W-1:0] rsp_b;
  logic         busy;
  logic         err;
  logic         we;
  logic [N-1:0] addr_rd;
  logic [W-1:0] data_in;
  logic [N-1:0] addr_rs1;
  logic [N-1:0] addr_rs2;
  logic [W-1:0] rs1;
  logic [W-1:0] rs2;

  logic [W-1:0] bank [16];
  logic         corrupt;

  typedef struct packed {logic [N-1:0] a; logic [W-1:0] d;} wr_t;
  typedef struct packed {logic [W-1:0] a; logic [W-1:0] b;} rsp_t;
  wr_t  exp_wr [$];
  rsp_t exp_rsp[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_bank_ctrl #(.W(W), .N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr_a (cmd_addr_a),
    .cmd_addr_b (cmd_addr_b),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_a      (rsp_a),
    .rsp_b      (rsp_b),
    .busy       (busy),
    .err        (err),
    .we         (we),
    .addr_rd    (addr_rd),
    .data_in    (data_in),
    .addr_rs1   (addr_rs1),
    .addr_rs2   (addr_rs2),
    .rs1        (rs1),
    .rs2        (rs2)
  );

  // Bank model: registered write, combinational read, optional bit-0 corruption on rs1.
  always @(posedge clk) if (we) bank[addr_rd] <= data_in;
  assign rs1 = bank[addr_rs1] ^ W'(corrupt);
  assign rs2 = bank[addr_rs2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every write and every presented response is popped/compared against the queues.
  always @(negedge clk) begin : monitor
    wr_t  ew;
    rsp_t er;
    if (we) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h want none", addr_rd, data_in);
      end else begin
        ew = exp_wr.pop_front();
        chk("wr_addr", 32'(addr_rd), 32'(ew.a));
        chk("wr_data", 32'(data_in), 32'(ew.d));
      end
    end
    if (rsp_valid) begin
      if (exp_rsp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got %0h/%0h want none", rsp_a, rsp_b);
      end else begin
        er = exp_rsp[0];
        chk("rsp_a", 32'(rsp_a), 32'(er.a));
        chk("rsp_b", 32'(rsp_b), 32'(er.b));
        if (rsp_ready) void'(exp_rsp.pop_front());
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_we"}, 32'(we), 0);
    chk({tag, "_addr_rd"}, 32'(addr_rd), 0);
    chk({tag, "_data_in"}, 32'(data_in), 0);
    chk({tag, "_addr_rs1"}, 32'(addr_rs1), 0);
    chk({tag, "_addr_rs2"}, 32'(addr_rs2), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_a"}, 32'(rsp_a), 0);
    chk({tag, "_rsp_b"}, 32'(rsp_b), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
  endtask

  // Present a command one cycle, accept on the next edge, then scramble the fields.
  task automatic issue(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [W-1:0] d);
    @(posedge clk); #1;
    cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_data = d; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = ~op; cmd_addr_a = ~a; cmd_addr_b = ~b; cmd_data = ~d;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (cmd_ready) return;
      if (busy) n++;
    end
    chk("idle_timeout", 32'(cmd_ready), 1);
  endtask

  task automatic push_sweep(input int first, input int count, input logic [W-1:0] d);
    for (int i = 0; i < count; i++) exp_wr.push_back('{a: N'((first + i) % 16), d: d});
  endtask

  task automatic do_read(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [W-1:0] ea, input logic [W-1:0] eb, input int hold);
    exp_rsp.push_back('{a: ea, b: eb});
    issue(OpRead, a, b, 7'h0);
    @(negedge clk); chk("rsp_valid_in_rd", 32'(rsp_valid), 0);
    @(negedge clk); chk("rsp_valid_in_cap", 32'(rsp_valid), 0);
    @(negedge clk); chk("rsp_valid_in_rsp", 32'(rsp_valid), 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); chk("rsp_valid_hold", 32'(rsp_valid), 1);
    end
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_valid_drop", 32'(rsp_valid), 0);
    chk("rsp_ready_idle", 32'(cmd_ready), 1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) bank[i] = '0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr_a = '0; cmd_addr_b = '0;
    cmd_data = '0; rsp_ready = 1'b0; corrupt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); check_reset_state("rst");
    @(posedge clk); #1; reset = 1'b0;

    exp_wr.push_back('{a: 4'd3, d: 7'h55});
    issue(OpWrite, 4'd3, 4'd0, 7'h55);
    wait_idle(n); chk("write_busy_cycles", 32'(n), 32'(WrCycles));

    do_read(4'd3, 4'd0, 7'h55, 7'h00, 5);

    push_sweep(14, 4, 7'h2A);
    issue(OpFill, 4'd14, 4'd1, 7'h2A);
    wait_idle(n); chk("fill_wrap_cycles", 32'(n), 4);
    do_read(4'd15, 4'd1, 7'h2A, 7'h2A, 0);

    push_sweep(5, 1, 7'h11);
    issue(OpFill, 4'd5, 4'd5, 7'h11);
    wait_idle(n); chk("fill_single_cycles", 32'(n), 1);
    do_read(4'd5, 4'd14, 7'h11, 7'h2A, 1);

    push_sweep(0, 16, 7'h00);
    issue(OpClear, 4'd7, 4'd9, 7'h7F);
    wait_idle(n); chk("clear_cycles", 32'(n), 16);
    do_read(4'd3, 4'd14, 7'h00, 7'h00, 0);

    // Reset lands during the third sweep write; addresses 0..2 are written, nothing after.
    push_sweep(0, 3, 7'h00);
    issue(OpClear, 4'd0, 4'd0, 7'h00);
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); check_reset_state("rst_sweep");
    @(posedge clk); #1; reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_sweep_wr_drained", 32'(exp_wr.size()), 0);

    exp_wr.push_back('{a: 4'd9, d: 7'h33});
    issue(OpWrite, 4'd9, 4'd0, 7'h33);
    wait_idle(n); chk("err_clean_write", 32'(err), 0);

    exp_wr.push_back('{a: 4'd9, d: 7'h4C});
    @(posedge clk); #1; corrupt = 1'b1;
    issue(OpWrite, 4'd9, 4'd0, 7'h4C);
    wait_idle(n); chk("err_after_bad_write", 32'(err), 32'(ErrExpect));
    @(posedge clk); #1; corrupt = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(err), 32'(ErrExpect));
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk); chk("err_cleared_by_reset", 32'(err), 0);

    chk("wr_queue_empty", 32'(exp_wr.size()), 0);
    chk("rsp_queue_empty", 32'(exp_rsp.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_bank_ctrl.md
REG_BANK_CTRL -- requirements
Module: reg_bank_ctrl

Interface
REQ-001 Parameters SHALL be: W, 7, data width; N, 4, address width (2^N registers).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid/cmd_ready  input/output  1/1  command handshake.
REQ-005 cmd_op  input  2  00 WRITE, 01 READ, 10 CLEAR, 11 FILL.
REQ-006 cmd_addr_a, cmd_addr_b  input  N  write/start address and second read/end address.
REQ-007 cmd_data  input  W  write/fill data.
REQ-008 rsp_valid/rsp_ready  output/input  1/1  read-response handshake.
REQ-009 rsp_a, rsp_b  output  W  captured read data.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 err  output  1  sticky readback-mismatch flag.
REQ-012 we, addr_rd, data_in  output  1/N/W  register-bank write port, all registered.
REQ-013 addr_rs1, addr_rs2  output  N/N  register-bank read addresses, registered.
REQ-014 rs1, rs2  input  W/W  register-bank read data; combinational function of addr_rs1/addr_rs2.

Function
REQ-015 FSM states SHALL be IDLE, WR, RD, CAP, RSP, SWEEP, VFY (VFY exists only with the Configuration macro).
REQ-016 cmd_ready SHALL be 1 exactly when state is IDLE; a command is accepted on cmd_valid&&cmd_ready.
REQ-017 WRITE: IDLE->WR; in WR we=1, addr_rd=cmd_addr_a, data_in=cmd_data for exactly one cycle, then IDLE (or VFY).
REQ-018 READ: IDLE->RD drives addr_rs1=cmd_addr_a, addr_rs2=cmd_addr_b; RD->CAP registers rs1->rsp_a, rs2->rsp_b; CAP->RSP asserts rsp_valid.
REQ-019 In RSP, rsp_valid and rsp_a/rsp_b SHALL hold stable until rsp_ready; on rsp_valid&&rsp_ready, rsp_valid drops next cycle and FSM returns to IDLE.
REQ-020 FILL: SWEEP writes cmd_data to addresses cmd_addr_a up to cmd_addr_b inclusive, one write per cycle, incrementing modulo 2^N.
REQ-021 FILL with cmd_addr_b < cmd_addr_a SHALL wrap through 2^N-1 to 0; equal addresses SHALL give exactly one write.
REQ-022 CLEAR SHALL behave as FILL with start 0, end 2^N-1, data 0: exactly 2^N write cycles.
REQ-023 we SHALL be 0 in every state except WR and SWEEP; read-address outputs keep their last value otherwise.
REQ-024 Command fields SHALL be latched at acceptance; changes on cmd_* while busy SHALL have no effect.

Reset
REQ-025 While reset is 1 on a clock edge: state=IDLE, we=0, addr_rd/addr_rs1/addr_rs2/data_in=0, rsp_valid=0, rsp_a/rsp_b=0, err=0, busy=0.
REQ-026 Reset mid-SWEEP or mid-RSP SHALL abort at that edge; no further write occurs and the pending response is discarded.

Configuration
REQ-027 Macro REG_BANK_CTRL_READBACK_EN defined: after each WR cycle, VFY drives addr_rs1=written address for one cycle, compares rs1 with written data, sets err on mismatch, then IDLE (WRITE occupies 2 busy cycles).
REQ-028 Macro undefined: no VFY state, WR returns directly to IDLE, err SHALL be constant 0.

Structure
REQ-029 Package reg_bank_pkg SHALL hold the cmd_op enum type and the FSM state enum type.
REQ-030 Address-sweep counter with wrap/terminal detection SHALL be sub-module reg_bank_sweep_cnt.

Verification
REQ-031 WRITE addr 3 data 0x55 -> one cycle we=1, addr_rd=3, data_in=0x55; cmd_ready back next cycle.
REQ-032 READ a=3,b=0 after that write, bank model -> rsp_valid=1 two cycles after RD with rsp_a=0x55; holds 5 cycles with rsp_ready=0.
REQ-033 FILL a=14,b=1 data 0x2A -> writes to 14,15,0,1 in consecutive cycles, then IDLE.
REQ-034 CLEAR -> 16 write cycles addresses 0..15, data 0, busy high throughout.
REQ-035 Reset asserted at 3rd SWEEP cycle of CLEAR -> we=0 next cycle, all outputs at reset values.
REQ-036 With REG_BANK_CTRL_READBACK_EN and bank model forcing bit 0 wrong -> err=1 after WRITE, stays 1 until reset.
